// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared definitions for the single-cycle MIPS datapath.
//   REG_ZERO / REG_RA  : architectural register indices ($0, $31)
//   WD_*               : write-data select encodings (ALU / DM / PC+4)
//   A3_*               : write-address select encodings (rt / rd / $31)
//   PC_RESET_DEFAULT   : PC value after reset
package cpu_defs_pkg;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd31;

  localparam logic [1:0]  WD_ALU   = 2'b00;
  localparam logic [1:0]  WD_DM    = 2'b01;
  localparam logic [1:0]  WD_PC4   = 2'b10;

  localparam logic [1:0]  A3_RT    = 2'b00;
  localparam logic [1:0]  A3_RD    = 2'b01;
  localparam logic [1:0]  A3_RA    = 2'b10;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
endpackage

// File: rtl/grf_wdec.sv
// grf_wdec: write-index decoder for the register file.
//   we_i   : write enable
//   addr_i : write index
//   wen_o  : one-hot per-register write enable, gated by we_i; bit 0 is
//            always 0 because $0 is not a storage element.
module grf_wdec #(
  parameter int ADDR_W = 5,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NREG-1:0]   wen_o
);
  always_comb begin
    wen_o = '0;
    // Starting at 1 keeps the $0 strobe tied low. An X on addr_i makes the
    // compare X, which the if treats as false, so no strobe fires.
    for (int i = 1; i < NREG; i++) begin
      if (addr_i == ADDR_W'(i)) wen_o[i] = we_i;
    end
  end
endmodule

// File: rtl/grf_wb_port.sv
// grf_wb_port: general register file terminating the write-back path.
//   clk, reset_n      : clock, synchronous active-low reset
//   we, a3, wd, pc    : write enable, write index, write data, PC of writer
//   a1/rd1, a2/rd2    : combinational read ports ($0 reads as 0)
//   wr_fire           : 1 for one cycle after a committed write
//   last_pc/a3/wd     : PC, index and data of the most recent committed write
// Build option: define GRF_BYPASS_EN to forward same-cycle write data to
// the read ports; otherwise a same-cycle read returns the old value.
module grf_wb_port
  import cpu_defs_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  PC_RESET = DATA_W'(PC_RESET_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              wr_fire,
  output logic [DATA_W-1:0] last_pc,
  output logic [ADDR_W-1:0] last_a3,
  output logic [DATA_W-1:0] last_wd
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   wen;
  logic              commit;

  logic              wr_fire_q, wr_fire_d;
  logic [DATA_W-1:0] last_pc_q, last_pc_d;
  logic [ADDR_W-1:0] last_a3_q, last_a3_d;
  logic [DATA_W-1:0] last_wd_q, last_wd_d;

  grf_wdec #(.ADDR_W(ADDR_W)) u_wdec (
    .we_i   (we),
    .addr_i (a3),
    .wen_o  (wen)
  );

  assign commit = we && (a3 != ZERO);

  // Entry 0 is never strobed; the read mux masks it regardless.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wen[i]) regs_q[i] <= wd;
      end
    end
  end

  // An X commit falls to the else path: wr_fire drops and last_* hold.
  always_comb begin
    wr_fire_d = 1'b0;
    last_pc_d = last_pc_q;
    last_a3_d = last_a3_q;
    last_wd_d = last_wd_q;
    if (commit) begin
      wr_fire_d = 1'b1;
      last_pc_d = pc;
      last_a3_d = a3;
      last_wd_d = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_fire_q <= 1'b0;
      last_pc_q <= PC_RESET;
      last_a3_q <= '0;
      last_wd_q <= '0;
    end else begin
      wr_fire_q <= wr_fire_d;
      last_pc_q <= last_pc_d;
      last_a3_q <= last_a3_d;
      last_wd_q <= last_wd_d;
    end
  end

  always_comb begin
    rd1 = (a1 == ZERO) ? '0 : regs_q[a1];
    rd2 = (a2 == ZERO) ? '0 : regs_q[a2];
`ifdef GRF_BYPASS_EN
    // commit already excludes $0, so $0 reads stay 0.
    if (commit && (a1 == a3)) rd1 = wd;
    if (commit && (a2 == a3)) rd2 = wd;
`endif
  end

  assign wr_fire = wr_fire_q;
  assign last_pc = last_pc_q;
  assign last_a3 = last_a3_q;
  assign last_wd = last_wd_q;
endmodule

// File: tb/tb_grf_wb_port.sv
module tb_grf_wb_port;
  logic        clk, reset_n, we, wr_fire;
  logic [4:0]  a1, a2, a3, last_a3;
  logic [31:0] wd, pc, rd1, rd2, last_pc, last_wd;

  grf_wb_port dut (
    .clk(clk), .reset_n(reset_n), .we(we), .a1(a1), .a2(a2), .a3(a3),
    .wd(wd), .pc(pc), .rd1(rd1), .rd2(rd2), .wr_fire(wr_fire),
    .last_pc(last_pc), .last_a3(last_a3), .last_wd(last_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_RD1, S_RD2, S_FIRE, S_LPC, S_LA3, S_LWD} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_RD1:   return rd1;
      S_RD2:   return rd2;
      S_FIRE:  return {31'd0, wr_fire};
      S_LPC:   return last_pc;
      S_LA3:   return {27'd0, last_a3};
      default: return last_wd;
    endcase
  endfunction

  task automatic expect_v(string name, sig_e s, logic [31:0] e);
    chk_t c;
    c.name = name; c.sig = s; c.exp = e;
    q.push_back(c);
  endtask

  // Inputs change 1ns after the active edge; monitor samples on negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains every expectation queued for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        chk_t c;
        logic [31:0] a;
        c = q.pop_front();
        a = actual(c.sig);
        checks++;
        if (a !== c.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
        end
      end
    end
  end

  // Watchdog keeps the run bounded whatever happens.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: stimulus did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
    end
  end

  function automatic logic [31:0] pat(int i);
    return 32'h0101_0101 * i ^ 32'hA5A5_0000;
  endfunction

  initial begin
    reset_n = 0; we = 1; a1 = 0; a2 = 0; a3 = 5; wd = 32'hDEAD_BEEF; pc = 0;
    step();
    // Reset state
    reset_n = 1; we = 0;
    expect_v("rst_fire", S_FIRE, 0);
    expect_v("rst_lpc",  S_LPC,  32'h0000_3000);
    expect_v("rst_la3",  S_LA3,  0);
    expect_v("rst_lwd",  S_LWD,  0);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      expect_v("rst_rd1", S_RD1, 0);
      expect_v("rst_rd2", S_RD2, 0);
      step();
    end

    // Basic write/read
    we = 1; a3 = 8; wd = 32'h1234_5678; pc = 32'h3004;
    step();
    we = 0; a1 = 8;
    expect_v("wr_rd1",  S_RD1,  32'h1234_5678);
    expect_v("wr_fire", S_FIRE, 1);
    expect_v("wr_lpc",  S_LPC,  32'h3004);
    expect_v("wr_la3",  S_LA3,  8);
    expect_v("wr_lwd",  S_LWD,  32'h1234_5678);
    step();
    expect_v("wr_fire_1cyc", S_FIRE, 0);
    expect_v("wr_lpc_hold",  S_LPC,  32'h3004);

    // $0 write is a no-op
    we = 1; a3 = 0; wd = 32'hFFFF_FFFF; pc = 32'h3008; a1 = 0;
    expect_v("z_rd1_pre", S_RD1, 0);
    step();
    we = 0;
    expect_v("z_rd1",  S_RD1,  0);
    expect_v("z_fire", S_FIRE, 0);
    expect_v("z_lpc",  S_LPC,  32'h3004);
    expect_v("z_la3",  S_LA3,  8);
    expect_v("z_lwd",  S_LWD,  32'h1234_5678);
    step();

    // jal path
    we = 1; a3 = 31; wd = 32'h0000_3010; pc = 32'h300C;
    step();
    we = 0; a2 = 31;
    expect_v("jal_rd2", S_RD2, 32'h0000_3010);
    expect_v("jal_la3", S_LA3, 31);
    expect_v("jal_lpc", S_LPC, 32'h300C);
    step();

    // Same-cycle read/write
    we = 1; a3 = 9; wd = 32'h1; a1 = 0; a2 = 0;
    step();
    we = 1; a3 = 9; a1 = 9; wd = 32'h2;
`ifdef GRF_BYPASS_EN
    expect_v("same_pre", S_RD1, 32'h2);
`else
    expect_v("same_pre", S_RD1, 32'h1);
`endif
    step();
    we = 0;
    expect_v("same_post", S_RD1, 32'h2);
    step();
    // $0 never forwards
    we = 1; a3 = 0; a1 = 0; wd = 32'h5;
    expect_v("z_bypass", S_RD1, 0);
    step();
    we = 0;

    // Every index holds distinct data (decoder coverage)
    for (int i = 1; i < 32; i++) begin
      we = 1; a3 = 5'(i); wd = pat(i); pc = 32'h4000 + 32'(i * 4);
      step();
    end
    we = 0;
    for (int i = 1; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(32 - i);
      expect_v("all_rd1", S_RD1, pat(i));
      expect_v("all_rd2", S_RD2, pat(32 - i));
      step();
    end

    // Back-to-back writes, then reset mid-run
    we = 1; a3 = 3; wd = 32'hA; pc = 32'h5000; a1 = 3;
    step();
    wd = 32'hB; pc = 32'h5004;
    expect_v("b2b_fire1", S_FIRE, 1);
    expect_v("b2b_lwd1",  S_LWD,  32'hA);
    step();
    we = 0;
    expect_v("b2b_fire2", S_FIRE, 1);
    expect_v("b2b_lwd2",  S_LWD,  32'hB);
    expect_v("b2b_lpc2",  S_LPC,  32'h5004);
    expect_v("b2b_rd1",   S_RD1,  32'hB);
    step();
    reset_n = 0; we = 1; a3 = 3; wd = 32'hC;
    step();
    reset_n = 1; we = 0; a2 = 8;
    expect_v("mid_rst_rd1",  S_RD1,  0);
    expect_v("mid_rst_rd2",  S_RD2,  0);
    expect_v("mid_rst_fire", S_FIRE, 0);
    expect_v("mid_rst_lpc",  S_LPC,  32'h0000_3000);
    expect_v("mid_rst_la3",  S_LA3,  0);
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grf_wb_port.md
Name: grf_wb_port

Overview:
- General register file (GRF) that terminates the write-back path of the single-cycle MIPS core.
- Receives the already-selected write address (rt / rd / $31) and write data (ALU / DM / PC+4).
- Decodes the 5-bit address to a one-hot write strobe and commits on the clock edge.
- Serves the two combinational read ports used by the decode stage.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- PC_RESET, 32'h0000_3000, reset value of the last_pc debug output

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- we  in  1  write enable from the controller (RegWrite)
- a1  in  ADDR_W  read port 1 index (rs)
- a2  in  ADDR_W  read port 2 index (rt)
- a3  in  ADDR_W  write index, already muxed (rt / rd / 31)
- wd  in  DATA_W  write data, already muxed (ALU / DM / PC+4)
- pc  in  DATA_W  PC of the instruction performing the write
- rd1  out  DATA_W  read data 1
- rd2  out  DATA_W  read data 2
- wr_fire  out  1  registered; 1 for one cycle after a committed write
- last_pc  out  DATA_W  registered; PC of the most recent committed write
- last_a3  out  ADDR_W  registered; index of the most recent committed write
- last_wd  out  DATA_W  registered; data of the most recent committed write

Behaviour:
- Reset: if reset_n == 0 at a rising edge, then:
  - registers 1..31 <= 0
  - wr_fire <= 0, last_pc <= PC_RESET, last_a3 <= 0, last_wd <= 0
  - reset overrides any concurrent write (we is ignored in that cycle).
- Commit: a write commits iff reset_n == 1, we == 1 and a3 != 0.
  - On commit: reg[a3] <= wd, wr_fire <= 1, last_pc <= pc, last_a3 <= a3, last_wd <= wd.
  - Otherwise wr_fire <= 0 and last_* hold their values.
- Register $0:
  - Not a storage element; always reads 0.
  - we == 1 with a3 == 0 is a legal no-op: no state change, wr_fire <= 0.
- Reads:
  - rd1 = (a1 == 0) ? 0 : reg[a1]; rd2 likewise with a2.
  - Purely combinational, zero latency.
  - Read and write indices equal in the same cycle: the read returns the OLD value. The new value is visible the cycle after the edge.
- Write latency: 1 edge. Back-to-back writes to the same index: the last one wins, each pulses wr_fire.
- Width: wd is stored verbatim (no extension or truncation). Index arithmetic is unsigned; no wrap because the index is exactly ADDR_W bits.
- X handling: a3 or we containing X while we is not 0 must leave registers unchanged. Simulation only; synthesis treats it as don't-care.

Optional Feature:
- Macro: GRF_BYPASS_EN
- Defined:
  - Internal write-to-read forwarding.
  - If we == 1, a3 != 0 and a1 == a3, then rd1 = wd in the same cycle; same for rd2 with a2.
  - Reads of $0 still return 0.
  - wr_fire and last_* are unchanged by this feature.
- Undefined: same-cycle reads return the old value, as stated under Behaviour.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31
  - Write-data select encodings: WD_ALU = 2'b00, WD_DM = 2'b01, WD_PC4 = 2'b10
  - Write-address select encodings: A3_RT = 2'b00, A3_RD = 2'b01, A3_RA = 2'b10
  - PC_RESET default value
- One sub-module: grf_wdec.
  - Combinational ADDR_W-to-2**ADDR_W one-hot decoder gated by we.
  - Output bit 0 is forced to 0.
  - The register array uses its outputs as per-register write enables.

Test Plan:
- Reset: drive reset_n = 0 for one edge with we = 1, a3 = 5, wd = 32'hDEAD_BEEF -> rd1 = rd2 = 0 for every index; wr_fire = 0; last_pc = 32'h0000_3000.
- Basic write/read: we = 1, a3 = 8, wd = 32'h1234_5678, pc = 32'h3004 -> after the edge, a1 = 8 gives rd1 = 32'h1234_5678; wr_fire = 1 for exactly one cycle; last_pc = 32'h3004, last_a3 = 8.
- $0 write: we = 1, a3 = 0, wd = 32'hFFFF_FFFF -> a1 = 0 gives rd1 = 0; wr_fire stays 0; last_* unchanged.
- jal path: a3 = 31, wd = 32'h0000_3010 (PC+4) -> a2 = 31 gives rd2 = 32'h0000_3010 on the next cycle.
- Same-cycle read/write: reg[9] = 32'h1, then we = 1, a3 = 9, a1 = 9, wd = 32'h2 -> before the edge rd1 = 32'h1 without GRF_BYPASS_EN, 32'h2 with it; after the edge rd1 = 32'h2 in both builds.
- Back-to-back and reset mid-run: write 32'hA then 32'hB to reg 3 on consecutive edges -> reads 32'hB, wr_fire high on both cycles; then reset_n = 0 with we = 1, a3 = 3 -> reg 3 reads 0.
